blink_sequencer: RTL and testbench

Programmable pattern controller for the `blinky` LED block. It steps through a small table of {enable, speed, duration} entries and drives `blinky`'s i_enable / i_speed inputs. It supports one-shot or looping playback with start/stop control. It sits between the board control logic and `blinky`. `blinky` itself is instantiated by the parent; this block only sequences it.

---
 rtl/blink_pkg.sv | 20 ++
 rtl/blink_sequencer_tick_divider.sv | 38 +++
 rtl/blink_sequencer.sv | 178 +++++++++++++++++
 tb/tb_blink_sequencer.sv | 267 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/blink_pkg.sv
// Shared sequencer state type and pattern-entry field helpers for the blinky family.
package blink_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    RUN  = 2'd2,
    DONE = 2'd3
  } state_t;

  // Entry layout is {enable, speed, duration[dur_width-1:0]}.
  function automatic int en_bit(input int dur_width);
    return dur_width + 1;
  endfunction

  function automatic int spd_bit(input int dur_width);
    return dur_width;
  endfunction

endpackage

// File: rtl/blink_sequencer_tick_divider.sv
// Free-running prescaler: o_tick fires on the cycle the count wraps from TICK_DIV-1.
module tick_divider #(
  parameter int TICK_DIV = 2500
) (
  input  logic i_clock,
  input  logic i_reset,
  input  logic i_clear,
  input  logic i_run,
  output logic o_tick
);

  localparam int            CW   = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(TICK_DIV - 1);

  logic [CW-1:0] r_count;
  logic          w_wrap;

  assign w_wrap = (r_count == LAST);
  assign o_tick = i_run && w_wrap;

  // prescaler count, cleared synchronously whenever the owner is not running
  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      r_count <= CW'(0);
    end else if (i_clear) begin
      r_count <= CW'(0);
    end else if (i_run) begin
      if (w_wrap) begin
        r_count <= CW'(0);
      end else begin
        r_count <= r_count + CW'(1);
      end
    end else begin
      r_count <= r_count;
    end
  end

endmodule

// File: rtl/blink_sequencer.sv
// Steps through a small {enable, speed, duration} table and drives blinky's inputs.
module blink_sequencer
  import blink_pkg::*;
#(
  parameter int STEPS     = 4,
  parameter int DUR_WIDTH = 8,
  parameter int TICK_DIV  = 2500
) (
  input  logic                     i_clock,
  input  logic                     i_reset,
  input  logic                     i_start,
  input  logic                     i_stop,
  input  logic                     i_loop,
  input  logic                     i_cfg_we,
  input  logic [$clog2(STEPS)-1:0] i_cfg_addr,
  input  logic [DUR_WIDTH+1:0]     i_cfg_data,
  output logic                     o_enable,
  output logic                     o_speed,
  output logic [$clog2(STEPS)-1:0] o_step,
  output logic                     o_busy,
  output logic                     o_done
);

  localparam int                 SW        = $clog2(STEPS);
  localparam int                 EN_BIT    = en_bit(DUR_WIDTH);
  localparam int                 SPD_BIT   = spd_bit(DUR_WIDTH);
  localparam logic [SW-1:0]      LAST_STEP = SW'(STEPS - 1);

  logic [DUR_WIDTH+1:0] r_table [STEPS];
  state_t               r_state;
  logic [SW-1:0]        r_step;
  logic [DUR_WIDTH-1:0] r_dur;
  logic                 r_enable;
  logic                 r_speed;
  logic                 r_busy;
  logic                 r_done;

  state_t               w_state_nxt;
  logic [SW-1:0]        w_step_nxt;
  logic [DUR_WIDTH-1:0] w_dur_nxt;
  logic                 w_enable_nxt;
  logic                 w_speed_nxt;
  logic                 w_done_nxt;
  logic                 w_tick;
  logic [DUR_WIDTH+1:0] w_entry;
  logic [DUR_WIDTH-1:0] w_entry_dur;

  assign w_entry     = r_table[r_step];
  assign w_entry_dur = w_entry[DUR_WIDTH-1:0];

  tick_divider #(
    .TICK_DIV (TICK_DIV)
  ) u_tick_divider (
    .i_clock (i_clock),
    .i_reset (i_reset),
    .i_clear (r_state != RUN),
    .i_run   (r_state == RUN),
    .o_tick  (w_tick)
  );

  // pattern table; a write lands on the next edge, so a running step keeps its loaded copy
  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      for (int i = 0; i < STEPS; i++) begin
        r_table[i] <= '0;
      end
    end else if (i_cfg_we) begin
      r_table[i_cfg_addr] <= i_cfg_data;
    end else begin
      r_table <= r_table;
    end
  end

  // next-state and next-output decode; stop outranks everything outside IDLE
  always_comb begin
    w_state_nxt  = r_state;
    w_step_nxt   = r_step;
    w_dur_nxt    = r_dur;
    w_enable_nxt = r_enable;
    w_speed_nxt  = r_speed;
    w_done_nxt   = 1'b0;
    if (i_stop && (r_state != IDLE)) begin
      w_state_nxt  = IDLE;
      w_step_nxt   = SW'(0);
      w_dur_nxt    = DUR_WIDTH'(0);
      w_enable_nxt = 1'b0;
      w_speed_nxt  = 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          w_enable_nxt = 1'b0;
          w_speed_nxt  = 1'b0;
          if (i_start && !i_stop) begin
            w_state_nxt = LOAD;
            w_step_nxt  = SW'(0);
          end else begin
            w_state_nxt = IDLE;
          end
        end
        LOAD: begin
          if (w_entry_dur == DUR_WIDTH'(0)) begin
            w_state_nxt  = DONE;
            w_done_nxt   = 1'b1;
            w_enable_nxt = 1'b0;
            w_speed_nxt  = 1'b0;
          end else begin
            w_state_nxt  = RUN;
            w_dur_nxt    = w_entry_dur;
            w_enable_nxt = w_entry[EN_BIT];
            w_speed_nxt  = w_entry[SPD_BIT];
          end
        end
        RUN: begin
          if (w_tick) begin
            w_dur_nxt = r_dur - DUR_WIDTH'(1);
            if (r_dur == DUR_WIDTH'(1)) begin
              if (r_step != LAST_STEP) begin
                w_state_nxt = LOAD;
                w_step_nxt  = r_step + SW'(1);
              end else if (i_loop) begin
                w_state_nxt = LOAD;
                w_step_nxt  = SW'(0);
              end else begin
                w_state_nxt  = DONE;
                w_done_nxt   = 1'b1;
                w_enable_nxt = 1'b0;
                w_speed_nxt  = 1'b0;
              end
            end else begin
              w_state_nxt = RUN;
            end
          end else begin
            w_state_nxt = RUN;
          end
        end
        DONE: begin
          w_state_nxt  = IDLE;
          w_enable_nxt = 1'b0;
          w_speed_nxt  = 1'b0;
        end
        default: begin
          w_state_nxt  = IDLE;
          w_step_nxt   = SW'(0);
          w_enable_nxt = 1'b0;
          w_speed_nxt  = 1'b0;
        end
      endcase
    end
  end

  // state and registered outputs
  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      r_state  <= IDLE;
      r_step   <= SW'(0);
      r_dur    <= DUR_WIDTH'(0);
      r_enable <= 1'b0;
      r_speed  <= 1'b0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
    end else begin
      r_state  <= w_state_nxt;
      r_step   <= w_step_nxt;
      r_dur    <= w_dur_nxt;
      r_enable <= w_enable_nxt;
      r_speed  <= w_speed_nxt;
      r_busy   <= (w_state_nxt != IDLE);
      r_done   <= w_done_nxt;
    end
  end

  assign o_enable = r_enable;
  assign o_speed  = r_speed;
  assign o_step   = r_step;
  assign o_busy   = r_busy;
  assign o_done   = r_done;

endmodule

// File: tb/tb_blink_sequencer.sv
// Directed, table-driven bench for blink_sequencer with TICK_DIV=4, DUR_WIDTH=8, STEPS=4.
module tb_blink_sequencer;

  localparam int STEPS     = 4;
  localparam int DUR_WIDTH = 8;
  localparam int TICK_DIV  = 4;

  typedef struct {
    int   edge_n;
    logic en;
    logic spd;
    logic [1:0] step;
    logic chk_step;
    logic busy;
    logic done;
  } vec_t;

  logic       clk      = 1'b0;
  logic       rst      = 1'b1;
  logic       start    = 1'b0;
  logic       stop     = 1'b0;
  logic       loop_s   = 1'b0;
  logic       cfg_we   = 1'b0;
  logic [1:0] cfg_addr = 2'd0;
  logic [9:0] cfg_data = 10'd0;
  logic       en;
  logic       spd;
  logic [1:0] step;
  logic       busy;
  logic       done;

  int   checks   = 0;
  int   failures = 0;
  vec_t vecs [10];

  blink_sequencer #(
    .STEPS     (STEPS),
    .DUR_WIDTH (DUR_WIDTH),
    .TICK_DIV  (TICK_DIV)
  ) dut (
    .i_clock    (clk),
    .i_reset    (rst),
    .i_start    (start),
    .i_stop     (stop),
    .i_loop     (loop_s),
    .i_cfg_we   (cfg_we),
    .i_cfg_addr (cfg_addr),
    .i_cfg_data (cfg_data),
    .o_enable   (en),
    .o_speed    (spd),
    .o_step     (step),
    .o_busy     (busy),
    .o_done     (done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic chk_out(input string tag, input logic e, input logic s, input logic [1:0] st,
                         input logic cs, input logic b, input logic d);
    chk({tag, ".enable"}, 32'(en), 32'(e));
    chk({tag, ".speed"}, 32'(spd), 32'(s));
    if (cs) chk({tag, ".step"}, 32'(step), 32'(st));
    chk({tag, ".busy"}, 32'(busy), 32'(b));
    chk({tag, ".done"}, 32'(done), 32'(d));
  endtask

  task automatic tick_edge();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic write_entry(input logic [1:0] a, input logic e, input logic s, input logic [7:0] d);
    cfg_we   = 1'b1;
    cfg_addr = a;
    cfg_data = {e, s, d};
    tick_edge();
    cfg_we   = 1'b0;
  endtask

  task automatic load_oneshot();
    write_entry(2'd0, 1'b1, 1'b1, 8'd3);
    write_entry(2'd1, 1'b1, 1'b0, 8'd2);
    write_entry(2'd2, 1'b0, 1'b0, 8'd1);
    write_entry(2'd3, 1'b1, 1'b1, 8'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int   vi;
    logic done_seen;

    // edge, en, spd, step, chk_step, busy, done (edge 0 samples i_start)
    vecs[0] = '{0,  1'b0, 1'b0, 2'd0, 1'b1, 1'b1, 1'b0};
    vecs[1] = '{1,  1'b1, 1'b1, 2'd0, 1'b1, 1'b1, 1'b0};
    vecs[2] = '{12, 1'b1, 1'b1, 2'd0, 1'b1, 1'b1, 1'b0};
    vecs[3] = '{13, 1'b1, 1'b1, 2'd1, 1'b1, 1'b1, 1'b0};
    vecs[4] = '{14, 1'b1, 1'b0, 2'd1, 1'b1, 1'b1, 1'b0};
    vecs[5] = '{22, 1'b1, 1'b0, 2'd2, 1'b1, 1'b1, 1'b0};
    vecs[6] = '{23, 1'b0, 1'b0, 2'd2, 1'b1, 1'b1, 1'b0};
    vecs[7] = '{27, 1'b0, 1'b0, 2'd3, 1'b1, 1'b1, 1'b0};
    vecs[8] = '{28, 1'b0, 1'b0, 2'd3, 1'b1, 1'b1, 1'b1};
    vecs[9] = '{29, 1'b0, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0};

    // reset state
    #12;
    chk_out("reset", 1'b0, 1'b0, 2'd0, 1'b1, 1'b0, 1'b0);
    @(negedge clk);
    rst = 1'b0;
    tick_edge();
    chk_out("idle_after_reset", 1'b0, 1'b0, 2'd0, 1'b1, 1'b0, 1'b0);

    // one-shot playback against the vector table
    load_oneshot();
    loop_s    = 1'b0;
    start     = 1'b1;
    vi        = 0;
    done_seen = 1'b0;
    for (int e = 0; e <= 29; e++) begin
      tick_edge();
      start = 1'b0;
      if (vi < 10 && vecs[vi].edge_n == e) begin
        chk_out($sformatf("oneshot_e%0d", e), vecs[vi].en, vecs[vi].spd, vecs[vi].step,
                vecs[vi].chk_step, vecs[vi].busy, vecs[vi].done);
        vi++;
      end
      if (e != 28) done_seen = done_seen | done;
    end
    chk("oneshot_done_only_e28", 32'(done_seen), 32'd0);
    chk("oneshot_vectors_applied", 32'(vi), 32'd10);

    // loop mode: every step is 5 cycles, no o_done
    for (int a = 0; a < 4; a++) write_entry(2'(a), 1'b1, 1'b0, 8'd1);
    loop_s    = 1'b1;
    start     = 1'b1;
    done_seen = 1'b0;
    for (int e = 0; e <= 27; e++) begin
      tick_edge();
      start = 1'b0;
      if (e % 5 == 0) chk($sformatf("loop_step_e%0d", e), 32'(step), 32'((e / 5) % 4));
      done_seen = done_seen | done;
    end
    chk("loop_no_done", 32'(done_seen), 32'd0);
    stop = 1'b1;
    tick_edge();
    stop   = 1'b0;
    loop_s = 1'b0;
    chk_out("loop_stop", 1'b0, 1'b0, 2'd0, 1'b1, 1'b0, 1'b0);

    // stop during step 1 of the one-shot pattern
    load_oneshot();
    start = 1'b1;
    for (int e = 0; e <= 16; e++) begin
      tick_edge();
      start = 1'b0;
    end
    chk_out("pre_stop_step1", 1'b1, 1'b0, 2'd1, 1'b1, 1'b1, 1'b0);
    stop = 1'b1;
    tick_edge();
    stop = 1'b0;
    chk_out("stop_midrun", 1'b0, 1'b0, 2'd0, 1'b1, 1'b0, 1'b0);
    tick_edge();
    chk_out("stop_settled", 1'b0, 1'b0, 2'd0, 1'b1, 1'b0, 1'b0);

    // start and stop together in IDLE: stop wins
    start = 1'b1;
    stop  = 1'b1;
    tick_edge();
    start = 1'b0;
    stop  = 1'b0;
    chk_out("start_stop_idle", 1'b0, 1'b0, 2'd0, 1'b1, 1'b0, 1'b0);
    tick_edge();
    chk("start_stop_idle_hold.busy", 32'(busy), 32'd0);

    // start pulsed while running must not restart or shift timing
    start = 1'b1;
    for (int e = 0; e <= 29; e++) begin
      tick_edge();
      start = (e == 5) ? 1'b1 : 1'b0;
      if (e == 6)  chk_out("busy_start_e6", 1'b1, 1'b1, 2'd0, 1'b1, 1'b1, 1'b0);
      if (e == 13) chk_out("busy_start_e13", 1'b1, 1'b1, 2'd1, 1'b1, 1'b1, 1'b0);
      if (e == 14) chk_out("busy_start_e14", 1'b1, 1'b0, 2'd1, 1'b1, 1'b1, 1'b0);
      if (e == 28) chk_out("busy_start_e28", 1'b0, 1'b0, 2'd3, 1'b1, 1'b1, 1'b1);
      if (e == 29) chk_out("busy_start_e29", 1'b0, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0);
    end

    // end marker at step 0
    write_entry(2'd0, 1'b1, 1'b1, 8'd0);
    start = 1'b1;
    tick_edge();
    start = 1'b0;
    chk_out("marker_e0", 1'b0, 1'b0, 2'd0, 1'b1, 1'b1, 1'b0);
    tick_edge();
    chk_out("marker_e1", 1'b0, 1'b0, 2'd0, 1'b1, 1'b1, 1'b1);
    tick_edge();
    chk_out("marker_e2", 1'b0, 1'b0, 2'd0, 1'b1, 1'b0, 1'b0);

    // asynchronous reset between edges while running
    load_oneshot();
    start = 1'b1;
    for (int e = 0; e <= 5; e++) begin
      tick_edge();
      start = 1'b0;
    end
    chk("pre_reset_running.enable", 32'(en), 32'd1);
    #2;
    rst = 1'b1;
    #1;
    chk_out("async_reset", 1'b0, 1'b0, 2'd0, 1'b1, 1'b0, 1'b0);
    @(negedge clk);
    rst   = 1'b0;
    start = 1'b1;
    tick_edge();
    start = 1'b0;
    chk_out("post_reset_e0", 1'b0, 1'b0, 2'd0, 1'b1, 1'b1, 1'b0);
    tick_edge();
    chk_out("post_reset_e1", 1'b0, 1'b0, 2'd0, 1'b1, 1'b1, 1'b1);
    tick_edge();
    chk("post_reset_e2.busy", 32'(busy), 32'd0);

    // live write to the running step takes effect on the next lap
    write_entry(2'd0, 1'b1, 1'b0, 8'd1);
    write_entry(2'd1, 1'b1, 1'b1, 8'd2);
    write_entry(2'd2, 1'b1, 1'b0, 8'd1);
    write_entry(2'd3, 1'b1, 1'b0, 8'd1);
    loop_s = 1'b1;
    start  = 1'b1;
    for (int e = 0; e <= 34; e++) begin
      tick_edge();
      start = 1'b0;
      if (e == 8) begin
        cfg_we   = 1'b1;
        cfg_addr = 2'd1;
        cfg_data = {1'b0, 1'b1, 8'd1};
      end else begin
        cfg_we = 1'b0;
      end
      if (e == 13) chk_out("live_e13", 1'b1, 1'b1, 2'd1, 1'b1, 1'b1, 1'b0);
      if (e == 14) chk_out("live_e14", 1'b1, 1'b1, 2'd2, 1'b1, 1'b1, 1'b0);
      if (e == 15) chk_out("live_e15", 1'b1, 1'b0, 2'd2, 1'b1, 1'b1, 1'b0);
      if (e == 29) chk_out("live_e29", 1'b1, 1'b0, 2'd1, 1'b1, 1'b1, 1'b0);
      if (e == 30) chk_out("live_e30", 1'b0, 1'b1, 2'd1, 1'b1, 1'b1, 1'b0);
      if (e == 34) chk_out("live_e34", 1'b0, 1'b1, 2'd2, 1'b1, 1'b1, 1'b0);
    end
    stop = 1'b1;
    tick_edge();
    stop   = 1'b0;
    loop_s = 1'b0;
    chk("live_stop.busy", 32'(busy), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
